// File: rtl/corner_coord_emitter.sv
// ccem_fifo: generic registered FIFO (storage array plus read/write pointers).
// Latency: a write in cycle N is visible on rd_vld/rd_dat in cycle N+1.
// Backpressure: full is exported, and the writer must not write while it is high.
//   Ports: wr_vld/wr_dat push an entry; rd_vld/rd_rdy/rd_dat pop the head.
module ccem_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             full,
  output logic             rd_vld,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      used;
  logic             do_push, do_pop;

  assign do_push = wr_vld && !full;
  assign do_pop  = rd_vld && rd_rdy;
  assign rd_vld  = (used != '0);
  assign full    = (used == DEPTH_C);
  assign rd_dat  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   used <= used + 1'b1;
        2'b01:   used <= used - 1'b1;
        default: used <= used;
      endcase
    end
  end

  // The storage array has no reset. The top level gates its outputs with rd_vld.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_dat;
  end
endmodule

// corner_coord_emitter: turns a corner-detector flag stream into (x,y) coordinates.
// Latency: a qualified corner reaches out_valid one cycle after its beat.
// Backpressure: none toward the detector. When the FIFO is full, the corner is dropped and out_overflow is set.
//   Ports: r_width/r_height/r_max_corners are latched on the in_frame_start pulse.
//   in_valid/in_is_corner carry the detector stream.
//   out_valid/out_ready/out_x/out_y form the FIFO head.
//   out_count, out_truncated and out_overflow report per-frame status.
module corner_coord_emitter #(
  parameter int COORD_BITS = 10,
  parameter int FIFO_DEPTH = 16,
  parameter int DELAY_ROWS = 5,
  parameter int DELAY_COLS = 16,
  parameter int BORDER     = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [COORD_BITS-1:0] r_width,
  input  logic [COORD_BITS-1:0] r_height,
  input  logic [15:0]           r_max_corners,
  input  logic                  in_frame_start,
  input  logic                  in_valid,
  input  logic                  in_is_corner,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [COORD_BITS-1:0] out_x,
  output logic [COORD_BITS-1:0] out_y,
  output logic [15:0]           out_count,
  output logic                  out_truncated,
  output logic                  out_overflow
);
  typedef enum logic [1:0] {S_IDLE, S_SKIP, S_ACTIVE, S_DONE} state_t;

  state_t                state, state_nxt;
  logic [COORD_BITS-1:0] width_q, height_q, cx, cy;
  logic [15:0]           max_q, count_q;
  logic [31:0]           skip_q, skip_load;
  logic                  trunc_q, ovf_q;
  logic                  beat_act, cx_wrap, last_beat, qualify, push, fifo_full;
  logic [COORD_BITS:0]   cx_e, cy_e, w_e, h_e, bord_e;
  logic [2*COORD_BITS-1:0] head_dat;
  logic                  head_vld;

  // This is the number of detector beats emitted before pixel (0,0) reaches the stream.
  assign skip_load = 32'(DELAY_ROWS) * 32'(r_width) + 32'(DELAY_COLS);

  // Widen by one bit so that the border compare cannot wrap for small images.
  assign cx_e   = {1'b0, cx};
  assign cy_e   = {1'b0, cy};
  assign w_e    = {1'b0, width_q};
  assign h_e    = {1'b0, height_q};
  assign bord_e = (COORD_BITS+1)'(BORDER);

  assign beat_act  = (state == S_ACTIVE) && in_valid && !in_frame_start;
  assign cx_wrap   = (cx_e + 1'b1 == w_e);
  assign last_beat = cx_wrap && (cy_e + 1'b1 == h_e);
  assign qualify   = beat_act && in_is_corner &&
                     (cx_e >= bord_e) && (cx_e + bord_e < w_e) &&
                     (cy_e >= bord_e) && (cy_e + bord_e < h_e);
  // The full check uses pre-pop occupancy: a pop in the same cycle does not make room.
  assign push      = qualify && (count_q != max_q) && !fifo_full;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (in_frame_start) begin
      state_nxt = (skip_load == 32'd0) ? S_ACTIVE : S_SKIP;
    end else begin
      case (state)
        S_SKIP:   if (in_valid && skip_q == 32'd1) state_nxt = S_ACTIVE;
        S_ACTIVE: if (beat_act && last_beat)       state_nxt = S_DONE;
        default:  state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      width_q  <= '0;
      height_q <= '0;
      max_q    <= '0;
      skip_q   <= '0;
      cx       <= '0;
      cy       <= '0;
      count_q  <= '0;
      trunc_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (in_frame_start) begin
      width_q  <= r_width;
      height_q <= r_height;
      max_q    <= r_max_corners;
      skip_q   <= skip_load;
      cx       <= '0;
      cy       <= '0;
      count_q  <= '0;
      trunc_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (state == S_SKIP && in_valid && skip_q != 32'd0) skip_q <= skip_q - 32'd1;
      if (beat_act) begin
        if (cx_wrap) begin
          cx <= '0;
          cy <= cy + 1'b1;
        end else begin
          cx <= cx + 1'b1;
        end
      end
      if (qualify) begin
        if (count_q == max_q) trunc_q <= 1'b1;
        else if (fifo_full)   ovf_q   <= 1'b1;
        else                  count_q <= count_q + 16'd1;
      end
    end
  end

  ccem_fifo #(
    .WIDTH (2*COORD_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_vld (push),
    .wr_dat ({cx, cy}),
    .full   (fifo_full),
    .rd_vld (head_vld),
    .rd_rdy (out_ready),
    .rd_dat (head_dat)
  );

  assign out_valid     = head_vld;
  assign out_x         = head_vld ? head_dat[2*COORD_BITS-1:COORD_BITS] : '0;
  assign out_y         = head_vld ? head_dat[COORD_BITS-1:0]            : '0;
  assign out_count     = count_q;
  assign out_truncated = trunc_q;
  assign out_overflow  = ovf_q;
endmodule

// File: doc/corner_coord_emitter.md
CORNER_COORD_EMITTER -- requirements
Module: corner_coord_emitter

Interface
REQ-001 SHALL have parameter COORD_BITS, default 10, width of coordinates and dimension registers.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, output FIFO entries (power of two).
REQ-003 SHALL have parameter DELAY_ROWS, default 5, corner-detector row latency.
REQ-004 SHALL have parameter DELAY_COLS, default 16, corner-detector clock latency.
REQ-005 SHALL have parameter BORDER, default 3, pixels rejected at each image edge.
REQ-006 SHALL have port clk  input  1  clock.
REQ-007 SHALL have port reset  input  1  reset; synchronous, active-high.
REQ-008 SHALL have port r_width  input  COORD_BITS  image width in pixels.
REQ-009 SHALL have port r_height  input  COORD_BITS  image height in rows.
REQ-010 SHALL have port r_max_corners  input  16  per-frame corner limit.
REQ-011 SHALL have port in_frame_start  input  1  one-cycle pulse before a frame's first beat.
REQ-012 SHALL have port in_valid  input  1  pixel beat qualifier from the corner detector.
REQ-013 SHALL have port in_is_corner  input  1  corner flag for the current beat.
REQ-014 SHALL have port out_valid  output  1  FIFO head valid.
REQ-015 SHALL have port out_ready  input  1  consumer accepts the head.
REQ-016 SHALL have port out_x  output  COORD_BITS  corner column.
REQ-017 SHALL have port out_y  output  COORD_BITS  corner row.
REQ-018 SHALL have port out_count  output  16  corners accepted in the current frame.
REQ-019 SHALL have port out_truncated  output  1  sticky: r_max_corners reached and a further corner was discarded.
REQ-020 SHALL have port out_overflow  output  1  sticky: a corner was dropped because the FIFO was full.

Function
REQ-021 SHALL latch r_width, r_height and r_max_corners on in_frame_start; mid-frame changes SHALL have no effect.
REQ-022 SHALL, on in_frame_start, load skip counter = DELAY_ROWS*r_width + DELAY_COLS, zero cx/cy/out_count, and clear out_truncated/out_overflow; FIFO contents are retained.
REQ-023 SHALL decrement the skip counter on each in_valid beat while it is nonzero; those beats are discarded regardless of in_is_corner.
REQ-024 SHALL, once skip = 0, treat each in_valid beat as coordinate (cx,cy), then advance cx; cx wraps r_width-1 -> 0 with cy+1.
REQ-025 SHALL enter state DONE when cy reaches r_height; beats in DONE are ignored until the next in_frame_start.
REQ-026 States: IDLE (after reset) -> SKIP (in_frame_start) -> ACTIVE (skip reaches 0) -> DONE (cy = r_height); in_frame_start from any state -> SKIP; if DELAY_ROWS*r_width + DELAY_COLS = 0, in_frame_start -> ACTIVE directly.
REQ-027 SHALL qualify a candidate when ACTIVE, in_valid = 1, in_is_corner = 1, BORDER <= cx < r_width-BORDER, and BORDER <= cy < r_height-BORDER.
REQ-028 SHALL, for a qualified candidate: if out_count = r_max_corners, discard and set out_truncated; else if FIFO full (pre-pop occupancy, same-cycle pop ignored), drop and set out_overflow without incrementing out_count; else push (cx,cy) and increment out_count.
REQ-029 FIFO SHALL be registered: an entry pushed in cycle N is visible on out_valid/out_x/out_y in cycle N+1 at the earliest.
REQ-030 SHALL pop the head when out_valid && out_ready; out_x/out_y SHALL hold stable while out_valid && !out_ready.
REQ-031 Simultaneous push and pop on a non-full FIFO SHALL both take effect; occupancy unchanged.
REQ-032 out_count SHALL saturate at r_max_corners; r_max_corners = 0 discards every candidate.

Reset
REQ-033 reset SHALL force state IDLE, FIFO empty, out_valid 0, out_x/out_y 0, out_count 0, out_truncated 0, out_overflow 0, skip/cx/cy 0.
REQ-034 reset SHALL take priority over in_frame_start and all beats in the same cycle; reset mid-frame discards FIFO contents and returns to IDLE (no emission until next in_frame_start).

Verification
REQ-035 Width 32, height 20, in_frame_start then one in_is_corner at beat 5*32+16+10*32+8 (all earlier beats 0) -> one output (8,10), out_count 1.
REQ-036 Same frame, corners at stream coords (2,10), (8,1), (29,10), (8,17) -> all rejected by border, out_valid never asserted.
REQ-037 out_ready held 0, 17 qualified corners with FIFO_DEPTH 16 -> 16 entries held, out_overflow 1, out_count 16; release out_ready -> 16 pops in order.
REQ-038 r_max_corners 3, 5 qualified corners with out_ready 1 -> 3 outputs, out_count 3, out_truncated 1; next in_frame_start clears both flags.
REQ-039 out_ready toggled 1/0 each cycle while pushing every cycle -> no loss, no duplicates, order preserved, out_x stable while stalled.
REQ-040 reset asserted one cycle with 4 entries queued and state ACTIVE -> out_valid 0 next cycle; subsequent corners ignored until in_frame_start.
